kernel_window_sequencer: RTL and testbench
==========================================

// Module: kernel_window_sequencer
// PURPOSE
//  Sequences a full-image 3x3 convolution over the EXE-stage convolution kernel.
//  - Reads 8-bit pixels from source memory and builds the 3x3 sliding window.
//  - Presents the window to the kernel as three 24-bit rows; captures the 16-bit result.
//  - Clamps the result to 8 bits and writes it to destination memory.
//  - Handles interior pixels only; border pixels of the destination are never written.
// PARAMETERS
//  IMG_W    64      image width in pixels (>=3, checked by elaboration assertion)
//  IMG_H    64      image height in pixels (>=3)
//  ADDR_W   16      memory address width (byte = pixel addressing)
//  SRC_BASE 16'h0000 source image base address
//  DST_BASE 16'h1000 destination image base address
// PORTS
//  clk        in   1      clock
//  rst        in   1      synchronous active-high reset
//  start      in   1      1-cycle request to convolve the whole image; ignored while busy
//  ksel_cfg   in   2      kernel select sampled at start (00 blur, 01 sharpen, 1x over-sharp)
//  busy       out  1      high from the cycle after accepted start until done
//  done       out  1      1-cycle pulse when the last pixel write has completed
//  rd_en      out  1      source read strobe
//  rd_addr    out  ADDR_W source read address
//  rd_data    in   8      read data, valid exactly 1 cycle after rd_en
//  win_row    out  3x24   window to kernel: [0]=top row; bits[7:0]=left, [23:16]=right column
//  ksel       out  2      latched kernel select, constant for the whole job
//  kresult    in   16     kernel result (combinational from win_row/ksel), read as signed
//  wr_en      out  1      destination write strobe
//  wr_addr    out  ADDR_W destination write address
//  wr_data    out  8      clamped pixel
// BEHAVIOUR
//  - Reset: state IDLE; busy, done, rd_en, wr_en = 0; addresses, wr_data, window, ksel = 0.
//  - States and transitions:
//    IDLE  -start-> PRIME. Latch ksel; y=1, x=1.
//    PRIME issues 9 reads, one per cycle, column-major (col x-1..x+1, rows y-1..y+1).
//    SLIDE issues 3 reads (rows y-1..y+1 of col x+1). Before the first read, the window
//          shifts left: col0<=col1, col1<=col2.
//    LAST  captures the final read beat.
//    EXEC  registers clamp(kresult).
//    WRITE pulses wr_en at DST_BASE + y*IMG_W + x. Next state is chosen in order:
//          - x<IMG_W-2: x++, go to SLIDE.
//          - else if y<IMG_H-2: x=1, y++, go to PRIME.
//          - else go to DONE.
//    DONE  pulses done for 1 cycle, then returns to IDLE.
//  - Read address: SRC_BASE + row*IMG_W + col. Row bases are held in registers; no multiplier.
//  - Read data is captured into window[row][col] on the cycle after the matching rd_en.
//  - Cycle counts per output: PRIME 12 (9+LAST+EXEC+WRITE); SLIDE 6.
//  - Total cycles: (IMG_H-2)*(12+6*(IMG_W-3)), plus 1 for DONE.
//  - Clamp: signed kresult <0 gives 0; >255 gives 255; otherwise kresult[7:0].
//  - win_row is stable from LAST through EXEC, so kresult settles in one cycle.
//  - Boundaries:
//    - start while busy: ignored, and ksel is not re-latched.
//    - start coincident with the DONE cycle: ignored.
//    - IMG_W==3: SLIDE is never entered.
//    - Last row of the image: the FSM goes to DONE, never PRIME.
//    - rst mid-job: all state is abandoned and outputs clear on the next edge; no further writes.
//    - rd_en and wr_en are never high in the same cycle.
// STRUCTURE
//  Shared package kernel_pkg:
//  - PIX_W=8.
//  - KSEL_BLUR=2'b00, KSEL_SHARPEN=2'b01, KSEL_OVERSHARP=2'b10.
//  - seq_state_t enum {IDLE,PRIME,SLIDE,LAST,EXEC,WRITE,DONE}.
//  - function clamp_u8(logic signed [15:0]).
//  Sub-module kernel_window_regs: the 3x3 pixel register file.
//  - Load by (row,col).
//  - Shift-left strobe.
//  - Packs the three 24-bit rows onto win_row.
// TESTING (bench instantiates the real kernel plus 1-cycle-latency memory models)
//  1. Latency: 3x3 image all 10, sharpen, start at cycle 0.
//     - Reads on cycles 1-9; one write on cycle 12: addr DST_BASE+4, data 10.
//     - done pulse on cycle 13.
//  2. Clamp: 3x3 image, sharpen.
//     - Centre 255, neighbours 0 -> 255.
//     - Centre 0, neighbours 255 -> 0 (raw -1020).
//  3. Slide: 4x3 image, over-sharp, ramp data.
//     - 12 reads total; writes to DST+5 and DST+6 only; 18 cycles to last write.
//     - Values match the golden model.
//  4. Busy protection: start pulsed mid-job with ksel_cfg changed.
//     - Job result unchanged; exactly one done pulse.
//  5. Reset mid-job: rst asserted during SLIDE.
//     - Next cycle: busy=0 and rd_en=wr_en=0, with no further writes.
//     - A fresh start then completes correctly.
//  6. Full frame: 64x64 image, random data, blur.
//     - 3844 writes, border untouched; all data matches the golden model.
//     - Cycle count is 62*(12+6*61)+1.

Source files
------------

// File: rtl/kernel_pkg.sv
// rtl/kernel_pkg.sv - shared constants, sequencer state encoding and result clamp helper
//
// Purpose: common definitions for the 3x3 convolution window sequencer.
//   PIX_W           pixel width in bits
//   KSEL_*          kernel select codes presented to the convolution kernel
//   seq_state_t     sequencer FSM states
//   clamp_u8()      saturates a signed 16-bit kernel result into an unsigned pixel
package kernel_pkg;

  localparam int PIX_W = 8;

  localparam logic [1:0] KSEL_BLUR      = 2'b00;
  localparam logic [1:0] KSEL_SHARPEN   = 2'b01;
  localparam logic [1:0] KSEL_OVERSHARP = 2'b10;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    PRIME = 3'd1,
    SLIDE = 3'd2,
    LAST  = 3'd3,
    EXEC  = 3'd4,
    WRITE = 3'd5,
    DONE  = 3'd6
  } seq_state_t;

  function automatic logic [PIX_W-1:0] clamp_u8(input logic signed [15:0] v);
    if (v < 16'sd0) begin
      clamp_u8 = '0;
    end else if (v > 16'sd255) begin
      clamp_u8 = '1;
    end else begin
      clamp_u8 = v[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/kernel_window_regs.sv
// rtl/kernel_window_regs.sv - 3x3 pixel register file feeding the convolution kernel
//
// Purpose: holds the current 3x3 window. A cell is written by (row,col); a shift
// strobe moves every row one column left so a new right column can be streamed in.
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset, clears every cell
//   shift_i      col0<=col1, col1<=col2 on all three rows
//   load_i       write load_data_i into cell (load_row_i, load_col_i)
//   load_row_i   row index 0..2 (0 = top)
//   load_col_i   column index 0..2 (0 = left)
//   load_data_i  pixel to store
//   win_row_o    packed rows; [r][7:0] = left column, [r][23:16] = right column
module kernel_window_regs
  import kernel_pkg::*;
(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     shift_i,
  input  logic                     load_i,
  input  logic [1:0]               load_row_i,
  input  logic [1:0]               load_col_i,
  input  logic [PIX_W-1:0]         load_data_i,
  output logic [2:0][3*PIX_W-1:0]  win_row_o
);

  logic [PIX_W-1:0] pix_q [3][3];
  logic [PIX_W-1:0] pix_d [3][3];

  // A load in the same cycle as a shift lands after the shift.
  always_comb begin
    pix_d = pix_q;
    if (shift_i) begin
      for (int r = 0; r < 3; r++) begin
        pix_d[r][0] = pix_q[r][1];
        pix_d[r][1] = pix_q[r][2];
      end
    end
    if (load_i) begin
      pix_d[load_row_i][load_col_i] = load_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int r = 0; r < 3; r++) begin
        for (int c = 0; c < 3; c++) begin
          pix_q[r][c] <= '0;
        end
      end
    end else begin
      pix_q <= pix_d;
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      win_row_o[r] = {pix_q[r][2], pix_q[r][1], pix_q[r][0]};
    end
  end

endmodule

// File: rtl/kernel_window_sequencer.sv
// rtl/kernel_window_sequencer.sv - full-image 3x3 convolution sequencer around an external kernel
//
// Purpose: walks every interior pixel of the source image, builds its 3x3 window
// from 1-cycle-latency reads, lets the combinational kernel compute a result,
// clamps it to 8 bits and writes it to the destination image. Border pixels of
// the destination are never written.
// Ports:
//   clk, rst    clock, synchronous active-high reset
//   start       1-cycle job request, ignored unless idle
//   ksel_cfg    kernel select sampled with an accepted start
//   busy, done  job in progress / 1-cycle completion pulse
//   rd_en, rd_addr, rd_data   source read port (data one cycle after rd_en)
//   win_row     window rows to the kernel, [0] = top row
//   ksel        kernel select latched for the whole job
//   kresult     signed kernel result
//   wr_en, wr_addr, wr_data   destination write port
module kernel_window_sequencer
  import kernel_pkg::*;
#(
  parameter int                IMG_W    = 64,
  parameter int                IMG_H    = 64,
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] SRC_BASE = '0,
  parameter logic [ADDR_W-1:0] DST_BASE = ADDR_W'(16'h1000)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [1:0]               ksel_cfg,
  output logic                     busy,
  output logic                     done,
  output logic                     rd_en,
  output logic [ADDR_W-1:0]        rd_addr,
  input  logic [PIX_W-1:0]         rd_data,
  output logic [2:0][3*PIX_W-1:0]  win_row,
  output logic [1:0]               ksel,
  input  logic [15:0]              kresult,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [PIX_W-1:0]         wr_data
);

  if (IMG_W < 3 || IMG_H < 3) begin : g_bad_size
    $error("kernel_window_sequencer: IMG_W and IMG_H must both be at least 3");
  end

  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] X_STOP   = ADDR_W'(IMG_W - 2);
  localparam logic [ADDR_W-1:0] Y_STOP   = ADDR_W'(IMG_H - 2);

  seq_state_t        state_q, state_d;
  logic [1:0]        ksel_q, ksel_d;
  logic [ADDR_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0] y_q, y_d;
  // Source addresses of window rows y-1, y, y+1 at column 0; stepped by IMG_W per row.
  logic [ADDR_W-1:0] rb_q [3];
  logic [ADDR_W-1:0] rb_d [3];
  logic [ADDR_W-1:0] dst_row_q, dst_row_d;
  logic [1:0]        rrow_q, rrow_d;
  logic [1:0]        rcol_q, rcol_d;
  logic [PIX_W-1:0]  res_q, res_d;

  // Remembers where the previous cycle's read belongs, so returning data lands in the right cell.
  logic              cap_v_q;
  logic [1:0]        cap_row_q;
  logic [1:0]        cap_col_q;

  logic [1:0]        ksel_norm;
  logic              win_shift;

  // Both 1x codes select over-sharp; latch the canonical code.
  assign ksel_norm = ksel_cfg[1] ? KSEL_OVERSHARP : (ksel_cfg[0] ? KSEL_SHARPEN : KSEL_BLUR);

  always_comb begin
    state_d   = state_q;
    ksel_d    = ksel_q;
    x_d       = x_q;
    y_d       = y_q;
    rb_d      = rb_q;
    dst_row_d = dst_row_q;
    rrow_d    = rrow_q;
    rcol_d    = rcol_q;
    res_d     = res_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PRIME;
          ksel_d    = ksel_norm;
          x_d       = ADDR_W'(1);
          y_d       = ADDR_W'(1);
          rb_d[0]   = SRC_BASE;
          rb_d[1]   = SRC_BASE + ROW_STEP;
          rb_d[2]   = SRC_BASE + ROW_STEP + ROW_STEP;
          dst_row_d = DST_BASE + ROW_STEP;
          rrow_d    = 2'd0;
          rcol_d    = 2'd0;
        end
      end
      // Column-major: rows advance fastest, so each column finishes before the next.
      PRIME: begin
        if (rrow_q == 2'd2) begin
          rrow_d = 2'd0;
          if (rcol_q == 2'd2) begin
            state_d = LAST;
          end else begin
            rcol_d = rcol_q + 2'd1;
          end
        end else begin
          rrow_d = rrow_q + 2'd1;
        end
      end
      SLIDE: begin
        if (rrow_q == 2'd2) begin
          rrow_d  = 2'd0;
          state_d = LAST;
        end else begin
          rrow_d = rrow_q + 2'd1;
        end
      end
      LAST: state_d = EXEC;
      EXEC: begin
        res_d   = clamp_u8($signed(kresult));
        state_d = WRITE;
      end
      WRITE: begin
        if (x_q < X_STOP) begin
          x_d     = x_q + ADDR_W'(1);
          rrow_d  = 2'd0;
          rcol_d  = 2'd2;
          state_d = SLIDE;
        end else if (y_q < Y_STOP) begin
          x_d       = ADDR_W'(1);
          y_d       = y_q + ADDR_W'(1);
          rb_d[0]   = rb_q[1];
          rb_d[1]   = rb_q[2];
          rb_d[2]   = rb_q[2] + ROW_STEP;
          dst_row_d = dst_row_q + ROW_STEP;
          rrow_d    = 2'd0;
          rcol_d    = 2'd0;
          state_d   = PRIME;
        end else begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      ksel_q    <= '0;
      x_q       <= '0;
      y_q       <= '0;
      for (int i = 0; i < 3; i++) begin
        rb_q[i] <= '0;
      end
      dst_row_q <= '0;
      rrow_q    <= '0;
      rcol_q    <= '0;
      res_q     <= '0;
      cap_v_q   <= 1'b0;
      cap_row_q <= '0;
      cap_col_q <= '0;
    end else begin
      state_q   <= state_d;
      ksel_q    <= ksel_d;
      x_q       <= x_d;
      y_q       <= y_d;
      rb_q      <= rb_d;
      dst_row_q <= dst_row_d;
      rrow_q    <= rrow_d;
      rcol_q    <= rcol_d;
      res_q     <= res_d;
      cap_v_q   <= rd_en;
      cap_row_q <= rrow_q;
      cap_col_q <= rcol_q;
    end
  end

  // Shift once as a slide begins; the first new-column pixel arrives a cycle later.
  assign win_shift = (state_q == SLIDE) && (rrow_q == 2'd0);

  kernel_window_regs u_window (
    .clk_i       (clk),
    .rst_i       (rst),
    .shift_i     (win_shift),
    .load_i      (cap_v_q),
    .load_row_i  (cap_row_q),
    .load_col_i  (cap_col_q),
    .load_data_i (rd_data),
    .win_row_o   (win_row)
  );

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign rd_en   = (state_q == PRIME) || (state_q == SLIDE);
  assign rd_addr = rd_en ? (rb_q[rrow_q] + x_q + ADDR_W'(rcol_q) - ADDR_W'(1)) : '0;
  assign wr_en   = (state_q == WRITE);
  assign wr_addr = wr_en ? (dst_row_q + x_q) : '0;
  assign wr_data = res_q;
  assign ksel    = ksel_q;

endmodule

// File: tb/tb_kernel_window_sequencer.sv
// tb/tb_kernel_window_sequencer.sv - directed bench for the 3x3 convolution window sequencer
module tb_kernel_window_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [1:0] ksel_cfg = 2'b00;
  logic clr_dst = 1'b0;

  // _a: 3x3 image, _b: 4x3 image, _c: 64x64 image
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic busy_a, busy_b, busy_c, done_a, done_b, done_c;
  logic rd_en_a, rd_en_b, rd_en_c, wr_en_a, wr_en_b, wr_en_c;
  logic [15:0] rd_addr_a, rd_addr_b, rd_addr_c, wr_addr_a, wr_addr_b, wr_addr_c;
  logic [7:0] rd_data_a = 8'd0, rd_data_b = 8'd0, rd_data_c = 8'd0;
  logic [7:0] wr_data_a, wr_data_b, wr_data_c;
  logic [2:0][23:0] win_a, win_b, win_c;
  logic [1:0] ksel_a, ksel_b, ksel_c;
  logic [15:0] kres_a, kres_b, kres_c;

  logic [7:0] src_mem [0:4095];
  logic [7:0] dst_mem [0:4095];
  int cyc = 0, wr_total = 0, rd_total = 0, clash_total = 0, last_wr_cyc = 0;
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  function automatic int kern(input logic [2:0][23:0] w, input logic [1:0] k);
    int p [3][3];
    int csum, esum;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        p[r][c] = int'(w[r][8*c +: 8]);
    csum = p[0][0] + p[0][2] + p[2][0] + p[2][2];
    esum = p[0][1] + p[1][0] + p[1][2] + p[2][1];
    if (k == 2'b00) return (csum + 2*esum + 4*p[1][1]) / 16;
    else if (k == 2'b01) return 5*p[1][1] - esum;
    else return 9*p[1][1] - esum - csum;
  endfunction

  function automatic logic [7:0] sat8(input int v);
    if (v < 0) return 8'd0;
    if (v > 255) return 8'd255;
    return 8'(v);
  endfunction

  function automatic logic [7:0] golden(input int w, input int x, input int y, input logic [1:0] k);
    logic [2:0][23:0] win;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        win[r][8*c +: 8] = src_mem[(y-1+r)*w + (x-1+c)];
    return sat8(kern(win, k));
  endfunction

  assign kres_a = 16'(kern(win_a, ksel_a));
  assign kres_b = 16'(kern(win_b, ksel_b));
  assign kres_c = 16'(kern(win_c, ksel_c));

  kernel_window_sequencer #(.IMG_W(3), .IMG_H(3)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .ksel_cfg(ksel_cfg), .busy(busy_a), .done(done_a),
    .rd_en(rd_en_a), .rd_addr(rd_addr_a), .rd_data(rd_data_a), .win_row(win_a), .ksel(ksel_a),
    .kresult(kres_a), .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a));

  kernel_window_sequencer #(.IMG_W(4), .IMG_H(3)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .ksel_cfg(ksel_cfg), .busy(busy_b), .done(done_b),
    .rd_en(rd_en_b), .rd_addr(rd_addr_b), .rd_data(rd_data_b), .win_row(win_b), .ksel(ksel_b),
    .kresult(kres_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b));

  kernel_window_sequencer u_c (
    .clk(clk), .rst(rst), .start(start_c), .ksel_cfg(ksel_cfg), .busy(busy_c), .done(done_c),
    .rd_en(rd_en_c), .rd_addr(rd_addr_c), .rd_data(rd_data_c), .win_row(win_c), .ksel(ksel_c),
    .kresult(kres_c), .wr_en(wr_en_c), .wr_addr(wr_addr_c), .wr_data(wr_data_c));

  // 1-cycle-latency memories; destination index is the offset from DST_BASE (0x1000).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    rd_data_a <= src_mem[rd_addr_a[11:0]];
    rd_data_b <= src_mem[rd_addr_b[11:0]];
    rd_data_c <= src_mem[rd_addr_c[11:0]];
    if (clr_dst)
      for (int i = 0; i < 4096; i++) dst_mem[i] <= 8'hA5;
    if (wr_en_a | wr_en_b | wr_en_c) begin
      wr_total <= wr_total + 1;
      last_wr_cyc <= cyc;
      if (wr_en_a) dst_mem[wr_addr_a[11:0]] <= wr_data_a;
      else if (wr_en_b) dst_mem[wr_addr_b[11:0]] <= wr_data_b;
      else dst_mem[wr_addr_c[11:0]] <= wr_data_c;
    end
    if (rd_en_a | rd_en_b | rd_en_c) rd_total <= rd_total + 1;
    if ((rd_en_a & wr_en_a) | (rd_en_b & wr_en_b) | (rd_en_c & wr_en_c))
      clash_total <= clash_total + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_dst();
    clr_dst = 1'b1;
    tick();
    clr_dst = 1'b0;
  endtask

  function automatic logic done_of(input int which);
    if (which == 0) return done_a;
    if (which == 1) return done_b;
    return done_c;
  endfunction

  // done_at is the cycle (start cycle = 0) in which done was seen, or -1 on timeout.
  task automatic run_job(input int which, input logic [1:0] kcfg, input int budget,
                         output int done_at, output int s0);
    int n;
    s0 = cyc;
    ksel_cfg = kcfg;
    if (which == 0) start_a = 1'b1;
    else if (which == 1) start_b = 1'b1;
    else start_c = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    n = 1;
    while (!done_of(which) && n < budget) begin
      tick();
      n++;
    end
    done_at = done_of(which) ? n : -1;
  endtask

  initial begin
    int s0, d, w0, r0, rd_mask, wcyc, waddr, wdata, dcyc, dcnt, k, bad_int, bad_bord;

    // ---- reset state ----
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_busy", busy_a, 0);
    check("rst_done", done_a, 0);
    check("rst_rd_en", rd_en_a, 0);
    check("rst_wr_en", wr_en_a, 0);
    check("rst_rd_addr", rd_addr_a, 0);
    check("rst_wr_addr", wr_addr_a, 0);
    check("rst_wr_data", wr_data_a, 0);
    check("rst_ksel", ksel_a, 0);
    check("rst_win", win_a, 0);
    check("rst_busy_c", busy_c, 0);

    // ---- 1: latency, 3x3 all 10, sharpen ----
    for (int i = 0; i < 9; i++) src_mem[i] = 8'd10;
    clear_dst();
    w0 = wr_total;
    rd_mask = 0; wcyc = -1; waddr = -1; wdata = -1; dcyc = -1; dcnt = 0;
    ksel_cfg = 2'b01;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int c = 1; c <= 14; c++) begin
      if (rd_en_a) rd_mask = rd_mask | (1 << c);
      if (c == 1) begin
        check("t1_busy_c1", busy_a, 1);
        check("t1_ksel", ksel_a, 2'b01);
      end
      if (c == 2) check("t1_addr_c2", rd_addr_a, 16'd3);
      if (c == 4) check("t1_addr_c4", rd_addr_a, 16'd1);
      if (c == 9) check("t1_addr_c9", rd_addr_a, 16'd8);
      if (wr_en_a) begin wcyc = c; waddr = wr_addr_a; wdata = wr_data_a; end
      if (done_a) begin dcyc = c; dcnt++; end
      tick();
    end
    check("t1_rd_cycles", rd_mask, 32'h3FE);
    check("t1_wr_cycle", wcyc, 12);
    check("t1_wr_addr", waddr, 16'h1004);
    check("t1_wr_data", wdata, 10);
    check("t1_done_cycle", dcyc, 13);
    check("t1_done_count", dcnt, 1);
    check("t1_writes", wr_total - w0, 1);
    check("t1_busy_after", busy_a, 0);

    // ---- 2: clamp, sharpen ----
    for (int i = 0; i < 9; i++) src_mem[i] = (i == 4) ? 8'd255 : 8'd0;
    clear_dst();
    run_job(0, 2'b01, 40, d, s0);
    check("t2_hi_done", d, 13);
    check("t2_hi_value", dst_mem[4], 255);
    for (int i = 0; i < 9; i++) src_mem[i] = (i == 4) ? 8'd0 : 8'd255;
    clear_dst();
    run_job(0, 2'b01, 40, d, s0);
    check("t2_lo_value", dst_mem[4], 0);

    // ---- 3: slide, 4x3 ramp, over-sharp ----
    for (int i = 0; i < 12; i++) src_mem[i] = 8'(i * 20);
    clear_dst();
    w0 = wr_total; r0 = rd_total;
    run_job(1, 2'b10, 60, d, s0);
    check("t3_done_cycle", d, 19);
    check("t3_reads", rd_total - r0, 12);
    check("t3_writes", wr_total - w0, 2);
    check("t3_last_wr_cycle", last_wr_cyc - s0, 18);
    check("t3_dst5", dst_mem[5], 100);
    check("t3_dst6", dst_mem[6], 120);
    check("t3_dst5_model", dst_mem[5], golden(4, 1, 1, 2'b10));
    check("t3_dst6_model", dst_mem[6], golden(4, 2, 1, 2'b10));
    check("t3_dst4_untouched", dst_mem[4], 8'hA5);
    check("t3_dst7_untouched", dst_mem[7], 8'hA5);

    // ---- 4: busy protection, and start coincident with DONE ----
    for (int i = 0; i < 9; i++) src_mem[i] = (i == 4) ? 8'd200 : 8'd10;
    clear_dst();
    ksel_cfg = 2'b01;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (4) tick();
    start_a = 1'b1;
    ksel_cfg = 2'b00;
    tick();
    start_a = 1'b0;
    check("t4_ksel_held", ksel_a, 2'b01);
    k = 6;
    while (!done_a && k < 40) begin
      tick();
      k++;
    end
    check("t4_done_cycle", k, 13);
    dcnt = done_a ? 1 : 0;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    check("t4_start_at_done_busy", busy_a, 0);
    check("t4_start_at_done_rd", rd_en_a, 0);
    for (int i = 0; i < 16; i++) begin
      if (done_a) dcnt++;
      tick();
    end
    check("t4_done_pulses", dcnt, 1);
    check("t4_result", dst_mem[4], 255);

    // ---- 5: reset during SLIDE on 4x3 ----
    for (int i = 0; i < 12; i++) src_mem[i] = 8'(i * 20);
    ksel_cfg = 2'b10;
    start_b = 1'b1;
    tick();
    start_b = 1'b0;
    repeat (12) tick();
    check("t5_in_slide_rd", rd_en_b, 1);
    check("t5_in_slide_addr", rd_addr_b, 16'd3);
    w0 = wr_total;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t5_rst_busy", busy_b, 0);
    check("t5_rst_rd_en", rd_en_b, 0);
    check("t5_rst_wr_en", wr_en_b, 0);
    repeat (10) tick();
    check("t5_no_more_writes", wr_total - w0, 0);
    clear_dst();
    run_job(1, 2'b10, 60, d, s0);
    check("t5_restart_done", d, 19);
    check("t5_restart_dst5", dst_mem[5], 100);
    check("t5_restart_dst6", dst_mem[6], 120);

    // ---- 6: full 64x64 frame, random data, blur ----
    for (int i = 0; i < 4096; i++) src_mem[i] = 8'($urandom_range(0, 255));
    clear_dst();
    w0 = wr_total;
    run_job(2, 2'b00, 30000, d, s0);
    check("t6_done_cycle", d, 62*(12 + 6*61) + 1);
    check("t6_writes", wr_total - w0, 3844);
    bad_int = 0; bad_bord = 0;
    for (int y = 0; y < 64; y++) begin
      for (int x = 0; x < 64; x++) begin
        if (x == 0 || y == 0 || x == 63 || y == 63) begin
          if (dst_mem[y*64 + x] !== 8'hA5) bad_bord++;
        end else if (dst_mem[y*64 + x] !== golden(64, x, y, 2'b00)) begin
          bad_int++;
        end
      end
    end
    check("t6_interior_bad", bad_int, 0);
    check("t6_border_bad", bad_bord, 0);
    check("t6_corner_px", dst_mem[65], golden(64, 1, 1, 2'b00));
    check("rd_wr_clash", clash_total, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
